// File: rtl/mq_sched_if.sv
// Bundle between the two code-block requesters, the MQ coder and mq_sched.
// slave is the scheduler's view; master is the requester/coder environment.
interface mq_sched_if #(
  parameter int CXW = 4
);
  logic [1:0]       req_valid;
  logic [1:0]       req_bit;
  logic [2*CXW-1:0] req_cx;
  logic [1:0]       req_last;
  logic [1:0]       req_ready;
  logic [7:0]       byte_out;
  logic [1:0]       byte_valid;
  logic [1:0]       blk_done;
  logic             busy;
  logic             mq_restart;
  logic             mq_bit;
  logic [CXW-1:0]   mq_cx;
  logic             mq_valid;
  logic             mq_update;
  logic             mq_flush;
  logic             mq_flush_done;
  logic [7:0]       mq_byte;
  logic             mq_byte_valid;
  logic             timeout_err;

  modport slave (
    input  req_valid, req_bit, req_cx, req_last,
    input  mq_update, mq_flush_done, mq_byte, mq_byte_valid,
    output req_ready, byte_out, byte_valid, blk_done, busy,
    output mq_restart, mq_bit, mq_cx, mq_valid, mq_flush, timeout_err
  );

  modport master (
    output req_valid, req_bit, req_cx, req_last,
    output mq_update, mq_flush_done, mq_byte, mq_byte_valid,
    input  req_ready, byte_out, byte_valid, blk_done, busy,
    input  mq_restart, mq_bit, mq_cx, mq_valid, mq_flush, timeout_err
  );
endinterface

// File: rtl/mq_sched.sv
// Two-requester round-robin scheduler sharing one MQ coder, one code-block per grant.
// Define MQ_SCHED_TIMEOUT_EN to add a watchdog that flushes a stalled code-block.
module mq_sched #(
  parameter int CXW    = 4,
  parameter int TO_CYC = 255
) (
  input logic        clk,
  input logic        rst,
  mq_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, CODE, FLUSH} state_t;

  state_t state_q, state_d;
  logic   g_q, g_d;
  logic   lastg_q, lastg_d;
  logic   timeout_hit;

  logic           sel_valid, sel_bit, sel_last;
  logic [CXW-1:0] sel_cx;

  logic [1:0]     req_ready_c, byte_valid_c, blk_done_c;
  logic           busy_c, mq_restart_c, mq_bit_c, mq_valid_c, mq_flush_c, timeout_err_c;
  logic [CXW-1:0] mq_cx_c;

  assign sel_valid = bus.req_valid[g_q];
  assign sel_bit   = bus.req_bit[g_q];
  assign sel_last  = bus.req_last[g_q];
  assign sel_cx    = g_q ? bus.req_cx[2*CXW-1:CXW] : bus.req_cx[CXW-1:0];

`ifdef MQ_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consecutive starved CODE cycles; any other cycle restarts it.
  always_comb begin
    cnt_d       = '0;
    timeout_hit = 1'b0;
    if (state_q == CODE && !sel_valid) begin
      if (cnt_q == CNT_W'(TO_CYC - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    lastg_d       = lastg_q;
    req_ready_c   = 2'b00;
    byte_valid_c  = 2'b00;
    blk_done_c    = 2'b00;
    mq_restart_c  = 1'b0;
    mq_valid_c    = 1'b0;
    mq_bit_c      = 1'b0;
    mq_cx_c       = '0;
    mq_flush_c    = 1'b0;
    timeout_err_c = 1'b0;
    busy_c        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          g_d     = (bus.req_valid == 2'b11) ? ~lastg_q : bus.req_valid[1];
          state_d = START;
        end
      end
      START: begin
        mq_restart_c = 1'b1;
        state_d      = CODE;
      end
      CODE: begin
        mq_valid_c       = sel_valid;
        mq_bit_c         = sel_bit;
        mq_cx_c          = sel_cx;
        req_ready_c[g_q] = bus.mq_update;
        if (sel_valid && bus.mq_update && sel_last) begin
          state_d = FLUSH;
        end else if (timeout_hit) begin
          timeout_err_c = 1'b1;
          state_d       = FLUSH;
        end
      end
      FLUSH: begin
        mq_flush_c = 1'b1;
        if (bus.mq_flush_done) begin
          blk_done_c[g_q] = 1'b1;
          lastg_d         = g_q;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Coder bytes belong to whoever holds the grant; nobody owns them in IDLE.
    if (state_q != IDLE) begin
      byte_valid_c[g_q] = bus.mq_byte_valid;
    end

    // Reset takes effect on the edge, so strobes are masked while it is asserted.
    if (rst) begin
      req_ready_c   = 2'b00;
      byte_valid_c  = 2'b00;
      blk_done_c    = 2'b00;
      mq_restart_c  = 1'b0;
      mq_valid_c    = 1'b0;
      mq_bit_c      = 1'b0;
      mq_cx_c       = '0;
      mq_flush_c    = 1'b0;
      timeout_err_c = 1'b0;
      busy_c        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      lastg_q <= 1'b1;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      lastg_q <= lastg_d;
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.byte_out    = bus.mq_byte;
  assign bus.byte_valid  = byte_valid_c;
  assign bus.blk_done    = blk_done_c;
  assign bus.busy        = busy_c;
  assign bus.mq_restart  = mq_restart_c;
  assign bus.mq_bit      = mq_bit_c;
  assign bus.mq_cx       = mq_cx_c;
  assign bus.mq_valid    = mq_valid_c;
  assign bus.mq_flush    = mq_flush_c;
  assign bus.timeout_err = timeout_err_c;

endmodule

// File: tb/tb_mq_sched.sv
// Directed self-checking bench for mq_sched: arbitration, coder handshake, flush, reset, watchdog.
// Timeout checks follow MQ_SCHED_TIMEOUT_EN, with TO_CYC set to 8.
module tb_mq_sched;
  localparam int CXW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mq_sched_if #(.CXW(CXW)) bus ();

  mq_sched #(.CXW(CXW), .TO_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] pat = 16'b0011110000001111;

  logic [1:0] t_valid [6] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
  logic [1:0] t_bit   [6] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
  logic [1:0] t_last  [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
  logic       t_upd   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       t_mqv   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] bits,
                               input logic [1:0] last, input logic upd, input logic done);
    bus.req_valid     = valid;
    bus.req_bit       = bits;
    bus.req_last      = last;
    bus.mq_update     = upd;
    bus.mq_flush_done = done;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] strobes();
    return {3'b000, bus.timeout_err, bus.busy, bus.mq_flush, bus.mq_valid, bus.mq_restart,
            bus.blk_done, bus.byte_valid, bus.req_ready, 2'b00};
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    rst = 1'b1;
    bus.req_cx        = '0;
    bus.mq_byte       = 8'h00;
    bus.mq_byte_valid = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step;
    step;

    // Requests and coder strobes present while reset is held must not leak out.
    applyStimulus(2'b11, 2'b11, 2'b11, 1'b1, 1'b1);
    bus.mq_byte_valid = 1'b1;
    #1;
    checkOutput("reset_strobes", strobes(), 16'h0000);
    step;
    checkOutput("reset_strobes_held", strobes(), 16'h0000);
    bus.mq_byte_valid = 1'b0;
    rst = 1'b0;

    // Single 16-symbol block from requester 0 with the coder always ready.
    bus.req_cx = {4'd0, 4'd4};
    applyStimulus(2'b01, {1'b0, pat[15]}, 2'b00, 1'b1, 1'b0);
    #1;
    checkOutput("idle_busy", 16'(bus.busy), 16'h0);
    step;
    checkOutput("blk0_restart", 16'(bus.mq_restart), 16'h1);
    checkOutput("blk0_start_mqvalid", 16'(bus.mq_valid), 16'h0);
    step;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2'b01, {1'b0, pat[15-i]}, {1'b0, (i == 15)}, 1'b1, 1'b0);
      #1;
      checkOutput("blk0_mqvalid", 16'(bus.mq_valid), 16'h1);
      checkOutput("blk0_bit", 16'(bus.mq_bit), 16'(pat[15-i]));
      checkOutput("blk0_cx", 16'(bus.mq_cx), 16'h4);
      checkOutput("blk0_ready", 16'(bus.req_ready), 16'h1);
      step;
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    #1;
    checkOutput("blk0_flush", 16'(bus.mq_flush), 16'h1);
    checkOutput("blk0_no_early_done", 16'(bus.blk_done), 16'h0);
    step;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    #1;
    checkOutput("blk0_done", 16'(bus.blk_done), 16'h1);
    step;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    #1;
    checkOutput("blk0_back_idle", 16'(bus.busy), 16'h0);
    checkOutput("blk0_done_once", 16'(bus.blk_done), 16'h0);

    // Both requesters valid from reset: 0, then 1, then 0 again.
    rst = 1'b1;
    step;
    rst = 1'b0;
    bus.req_cx = {4'd9, 4'd3};
    applyStimulus(2'b11, 2'b10, 2'b11, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      logic gexp;
      gexp = (k == 1);
      step;
      checkOutput("rr_restart", 16'(bus.mq_restart), 16'h1);
      step;
      checkOutput("rr_ready", 16'(bus.req_ready), gexp ? 16'h2 : 16'h1);
      checkOutput("rr_cx", 16'(bus.mq_cx), gexp ? 16'h9 : 16'h3);
      checkOutput("rr_bit", 16'(bus.mq_bit), 16'(gexp));
      step;
      checkOutput("rr_done", 16'(bus.blk_done), gexp ? 16'h2 : 16'h1);
      step;
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step;

    // Requester 1 with a stalling coder and an idle gap carrying a stray last.
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b1, 1'b0);
    step;
    checkOutput("stall_restart", 16'(bus.mq_restart), 16'h1);
    step;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(t_valid[i], t_bit[i], t_last[i], t_upd[i], 1'b0);
      #1;
      checkOutput("stall_mqvalid", 16'(bus.mq_valid), 16'(t_mqv[i]));
      checkOutput("stall_ready", 16'(bus.req_ready), t_upd[i] ? 16'h2 : 16'h0);
      checkOutput("stall_no_flush", 16'(bus.mq_flush), 16'h0);
      if (t_mqv[i]) checkOutput("stall_bit", 16'(bus.mq_bit), 16'(t_bit[i][1]));
      step;
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    bus.mq_byte       = 8'hA5;
    bus.mq_byte_valid = 1'b1;
    #1;
    checkOutput("flush_reached", 16'(bus.mq_flush), 16'h1);
    checkOutput("flush_byte_valid", 16'(bus.byte_valid), 16'h2);
    checkOutput("flush_blk_done", 16'(bus.blk_done), 16'h2);
    checkOutput("flush_byte_out", 16'(bus.byte_out), 16'hA5);
    step;
    checkOutput("idle_byte_dropped", 16'(bus.byte_valid), 16'h0);
    checkOutput("idle_byte_out", 16'(bus.byte_out), 16'hA5);
    bus.mq_byte_valid = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step;

    // Reset pulse in the middle of a block from requester 0.
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b1, 1'b0);
    step;
    step;
    checkOutput("midrst_coding", 16'(bus.mq_valid), 16'h1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_strobes_during", strobes(), 16'h0000);
    step;
    rst = 1'b0;
    #1;
    checkOutput("midrst_strobes_after", strobes(), 16'h0000);
    step;
    checkOutput("midrst_fresh_restart", 16'(bus.mq_restart), 16'h1);
    step;
    checkOutput("midrst_ready", 16'(bus.req_ready), 16'h1);
    applyStimulus(2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
    step;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    #1;
    checkOutput("midrst_done", 16'(bus.blk_done), 16'h1);
    step;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step;

    // Granted requester goes silent inside CODE.
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    step;
    step;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    #1;
`ifdef MQ_SCHED_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      checkOutput("wd_pulse", 16'(bus.timeout_err), 16'((i == 7)));
      checkOutput("wd_no_flush", 16'(bus.mq_flush), 16'h0);
      step;
    end
    checkOutput("wd_flush", 16'(bus.mq_flush), 16'h1);
    checkOutput("wd_pulse_end", 16'(bus.timeout_err), 16'h0);
`else
    for (int i = 0; i < 12; i++) begin
      checkOutput("starve_no_err", 16'(bus.timeout_err), 16'h0);
      checkOutput("starve_no_flush", 16'(bus.mq_flush), 16'h0);
      step;
    end
    applyStimulus(2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
    step;
    checkOutput("starve_flush", 16'(bus.mq_flush), 16'h1);
`endif
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    #1;
    checkOutput("starve_done", 16'(bus.blk_done), 16'h1);
    step;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
